// File: rtl/aes_key_expander.sv
// AES key schedule for 128/192/256-bit keys: one 32-bit word per step, streams Nr+1 round keys
// over valid/ready. SubWord goes through a SBOX_LAT-deep registered S-box pipeline.
module aes_key_expander #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:KEY_BITS-1] key_in,
  output logic                ready,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [0:127]        rk_data,
  output logic [3:0]          rk_idx,
  output logic                rk_last,
  output logic                done
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam logic [5:0] LastI   = 6'(4 * NR + 3);
  localparam logic [3:0] NkLast  = 4'(NK - 1);
  localparam logic [3:0] NrIdx   = 4'(NR);
  localparam logic [7:0] LatLast = 8'(SBOX_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StSubw, StDrain} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 by square-and-multiply, then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] win_q, win_d;
  logic [95:0]         acc_q, acc_d;
  logic [5:0]          i_q, i_d;
  logic [3:0]          kcnt_q, kcnt_d;
  logic [7:0]          rcon_q, rcon_d;
  logic [7:0]          lat_q, lat_d;
  logic [127:0]        out_q, out_d;
  logic                vld_q, vld_d;
  logic [3:0]          idx_q, idx_d;
  logic                last_q, last_d;
  logic [31:0]         sb_q [SBOX_LAT];

  logic [31:0] oldest, latest, sb_in, temp, word_plain, word_sub, new_word;
  logic        need_sub, hs, stall, produce;

  // Window holds w[i-Nk] (oldest, MSBs) .. w[i-1] (latest, LSBs).
  assign oldest     = win_q[KEY_BITS-1 -: 32];
  assign latest     = win_q[31:0];
  assign need_sub   = (i_q >= 6'(NK)) && ((kcnt_q == 4'd0) || ((NK == 8) && (kcnt_q == 4'd4)));
  assign sb_in      = (kcnt_q == 4'd0) ? {latest[23:0], latest[31:24]} : latest;
  assign temp       = (kcnt_q == 4'd0) ? (sb_q[SBOX_LAT-1] ^ {rcon_q, 24'h0}) : sb_q[SBOX_LAT-1];
  assign word_sub   = oldest ^ temp;
  assign word_plain = (i_q < 6'(NK)) ? oldest : (oldest ^ latest);
  assign hs         = vld_q && rk_ready;
  // Only the word that completes a round key needs a free output register.
  assign stall      = (i_q[1:0] == 2'd3) && vld_q && !rk_ready;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    acc_d    = acc_q;
    i_d      = i_q;
    kcnt_d   = kcnt_q;
    rcon_d   = rcon_q;
    lat_d    = lat_q;
    out_d    = out_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    last_d   = last_q;
    produce  = 1'b0;
    new_word = word_plain;
    ready    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          state_d = StRun;
          win_d   = key_in;
          i_d     = 6'd0;
          kcnt_d  = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      StRun: begin
        if (need_sub) begin
          state_d = StSubw;
          lat_d   = 8'd0;
        end else if (!stall) begin
          produce = 1'b1;
        end
      end
      StSubw: begin
        new_word = word_sub;
        if (lat_q != LatLast) begin
          lat_d = lat_q + 8'd1;
        end else if (!stall) begin
          produce = 1'b1;
        end
      end
      StDrain: begin
        if (hs) begin
          state_d = StIdle;
          done    = 1'b1;
          win_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (produce) begin
      win_d   = {win_q[KEY_BITS-33:0], new_word};
      acc_d   = {acc_q[63:0], new_word};
      state_d = (i_q == LastI) ? StDrain : StRun;
      i_d     = i_q + 6'd1;
      kcnt_d  = (kcnt_q == NkLast) ? 4'd0 : kcnt_q + 4'd1;
      if (need_sub && (kcnt_q == 4'd0)) rcon_d = xtime(rcon_q);
    end

    if (produce && (i_q[1:0] == 2'd3)) begin
      vld_d  = 1'b1;
      out_d  = {acc_q, new_word};
      idx_d  = i_q[5:2];
      last_d = (i_q[5:2] == NrIdx);
    end else if (hs) begin
      vld_d  = 1'b0;
      out_d  = '0;
      idx_d  = 4'd0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      acc_q   <= '0;
      i_q     <= 6'd0;
      kcnt_q  <= 4'd0;
      rcon_q  <= 8'h01;
      lat_q   <= 8'd0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      kcnt_q  <= kcnt_d;
      rcon_q  <= rcon_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Window is frozen while in StSubw, so the pipeline output settles on the right value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(SBOX_LAT); k++) sb_q[k] <= '0;
    end else begin
      sb_q[0] <= sub_word(sb_in);
      for (int k = 1; k < int'(SBOX_LAT); k++) sb_q[k] <= sb_q[k-1];
    end
  end

  assign rk_valid = vld_q;
  assign rk_data  = out_q;
  assign rk_idx   = idx_q;
  assign rk_last  = last_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: four instances (128/192/256, and 128 with a 3-cycle
// S-box), reference key schedule computed from FIPS-197 rules with a search-based S-box.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   start_v = 4'b0;
  logic [255:0] key_bus = '0;
  logic         rk_ready = 1'b1;
  logic [3:0]   ready_v, rk_valid_v, rk_last_v, done_v;
  logic [127:0] rk_data_v [4];
  logic [3:0]   rk_idx_v  [4];

  aes_key_expander #(.KEY_BITS(128), .SBOX_LAT(1)) u128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key_bus[255:128]), .ready(ready_v[0]),
    .rk_valid(rk_valid_v[0]), .rk_ready(rk_ready), .rk_data(rk_data_v[0]), .rk_idx(rk_idx_v[0]),
    .rk_last(rk_last_v[0]), .done(done_v[0]));
  aes_key_expander #(.KEY_BITS(192), .SBOX_LAT(1)) u192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key_bus[255:64]), .ready(ready_v[1]),
    .rk_valid(rk_valid_v[1]), .rk_ready(rk_ready), .rk_data(rk_data_v[1]), .rk_idx(rk_idx_v[1]),
    .rk_last(rk_last_v[1]), .done(done_v[1]));
  aes_key_expander #(.KEY_BITS(256), .SBOX_LAT(1)) u256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key_bus), .ready(ready_v[2]),
    .rk_valid(rk_valid_v[2]), .rk_ready(rk_ready), .rk_data(rk_data_v[2]), .rk_idx(rk_idx_v[2]),
    .rk_last(rk_last_v[2]), .done(done_v[2]));
  aes_key_expander #(.KEY_BITS(128), .SBOX_LAT(3)) u128s (
    .clk(clk), .rst(rst), .start(start_v[3]), .key_in(key_bus[255:128]), .ready(ready_v[3]),
    .rk_valid(rk_valid_v[3]), .rk_ready(rk_ready), .rk_data(rk_data_v[3]), .rk_idx(rk_idx_v[3]),
    .rk_last(rk_last_v[3]), .done(done_v[3]));

  typedef struct packed {
    logic         last;
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           sel = 0;
  bit           duty = 1'b0;
  bit           mon_en = 1'b0;
  bit           chk_timing = 1'b0;
  int           hs_cnt = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic [127:0] got [15];
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_t [11];

  localparam logic [255:0] K1 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] K2 =
    {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] K3 =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 rk_ready = duty ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [255:0] act);
    total++;
    bad++;
    $display("FAIL %s: got=%0h", name, act);
  endtask

  // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^
               inv[(b + 7) % 8] ^ c[b];
      sbox_t[x] = s;
    end
    rcon_t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic push_model(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    exp_t        e;
    int          nr;
    nr = nk + 6;
    for (int i = 0; i < 4 * nr + 4; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) t = sub_w({t[23:0], t[31:24]}) ^ {rcon_t[i / nk], 24'h0};
        else if (nk == 8 && i % nk == 4) t = sub_w(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      e.last = (r == nr);
      e.idx  = 4'(r);
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t         e;
    logic         prev_stall;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("others_quiet", 256'(rk_valid_v & ~(4'b1 << sel)), 256'(0));
      if (prev_stall) begin
        chk("stall_data", 256'(rk_data_v[sel]), 256'(prev_data));
        chk("stall_idx", 256'(rk_idx_v[sel]), 256'(prev_idx));
      end
      if (rk_valid_v[sel] && rk_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_key", 256'(rk_idx_v[sel]));
        end else begin
          e = exp_q.pop_front();
          chk("rk_data", 256'(rk_data_v[sel]), 256'(e.data));
          chk("rk_idx", 256'(rk_idx_v[sel]), 256'(e.idx));
          chk("rk_last", 256'(rk_last_v[sel]), 256'(e.last));
          chk("done", 256'(done_v[sel]), 256'(e.last));
          if (e.last && chk_timing) chk("done_cycle", 256'(cyc - acc_cyc), 256'(55));
        end
        got[rk_idx_v[sel]] = rk_data_v[sel];
        hs_cnt++;
      end else if (rk_valid_v[sel]) begin
        chk("done_no_hs", 256'(done_v[sel]), 256'(0));
      end
      prev_stall = rk_valid_v[sel] && !rk_ready;
      prev_data  = rk_data_v[sel];
      prev_idx   = rk_idx_v[sel];
    end
  end

  task automatic launch(input int s, input logic [255:0] key, input int nk);
    int n;
    n      = 0;
    sel    = s;
    hs_cnt = 0;
    @(negedge clk);
    while (!ready_v[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[s]) fail("ready_timeout", 256'(ready_v));
    push_model(key, nk);
    key_bus    = key;
    start_v[s] = 1'b1;
    acc_cyc    = cyc;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
  endtask

  task automatic finish_run();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ready_v[sel]) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0 || !ready_v[sel]) fail("run_timeout", 256'(exp_q.size()));
    exp_q.delete();
  endtask

  task automatic wait_hs(input int k);
    int n;
    n = 0;
    while (hs_cnt < k && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (hs_cnt < k) fail("hs_timeout", 256'(hs_cnt));
  endtask

  task automatic check_reset_outputs(input int s);
    chk("rst_ready", 256'(ready_v[s]), 256'(1));
    chk("rst_valid", 256'(rk_valid_v[s]), 256'(0));
    chk("rst_data", 256'(rk_data_v[s]), 256'(0));
    chk("rst_idx", 256'(rk_idx_v[s]), 256'(0));
    chk("rst_last", 256'(rk_last_v[s]), 256'(0));
    chk("rst_done", 256'(done_v[s]), 256'(0));
  endtask

  initial begin
    logic [255:0] rk;
    logic         seen;
    int           nks [4];
    nks = '{4, 6, 8, 4};
    build_tables();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) check_reset_outputs(s);
    rst    = 1'b0;
    mon_en = 1'b1;

    // AES-128 known answer with timing
    chk_timing = 1'b1;
    launch(0, K1, 4);
    finish_run();
    chk("restart_cycle", 256'(cyc - acc_cyc), 256'(56));
    chk_timing = 1'b0;
    chk("kat128_count", 256'(hs_cnt), 256'(11));
    chk("kat128_rk1", 256'(got[1]), 256'(128'ha0fafe17_88542cb1_23a33939_2a6c7605));
    chk("kat128_rk10", 256'(got[10]), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    launch(1, K2, 6);
    finish_run();
    chk("kat192_count", 256'(hs_cnt), 256'(13));
    chk("kat192_rk12", 256'(got[12]), 256'(128'he98ba06f_448c773c_8ecc7204_01002202));

    launch(2, K3, 8);
    finish_run();
    chk("kat256_count", 256'(hs_cnt), 256'(15));
    chk("kat256_rk14", 256'(got[14]), 256'(128'hfe4890d1_e6188d0b_046df344_706c631e));

    // Backpressure with the slow S-box
    duty = 1'b1;
    launch(3, K1, 4);
    finish_run();
    chk("bp_count", 256'(hs_cnt), 256'(11));
    chk("bp_rk10", 256'(got[10]), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < 4; s++) begin
        duty = (r != 1);
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        launch(s, rk, nks[s]);
        finish_run();
        chk("rand_count", 256'(hs_cnt), 256'(nks[s] + 7));
      end
    end

    // Reset mid-expansion
    duty = 1'b0;
    launch(0, K1, 4);
    wait_hs(4);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs(0);
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 seen = seen | rk_valid_v[0];
    end
    chk("post_rst_quiet", 256'(seen), 256'(0));
    mon_en = 1'b1;
    launch(0, K1, 4);
    finish_run();
    chk("post_rst_count", 256'(hs_cnt), 256'(11));
    chk("post_rst_rk10", 256'(got[10]), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));

    // Start while busy is ignored; no key material left after done
    launch(0, K1, 4);
    wait_hs(2);
    @(negedge clk);
    chk("busy_ready", 256'(ready_v[0]), 256'(0));
    key_bus    = K3;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    finish_run();
    chk("busy_count", 256'(hs_cnt), 256'(11));
    chk("busy_rk10", 256'(got[10]), 256'(128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6));
    chk("zero_window", 256'(u128.win_q), 256'(0));
    chk("zero_acc", 256'(u128.acc_q), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
